mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 49 ++++
 rtl/mem_arbiter.sv | 150 +++++++++++++++
 tb/tb_mem_arbiter.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bus bundle between two requesting masters, the arbiter and a single-port
// synchronous RAM. The slave modport is the arbiter's view; the master
// modport is the view of whatever drives the requests and models the RAM.
`timescale 1ns/1ps

interface mem_arbiter_if #(
  parameter int AW = 12
);
  // Master 0 (CPU) request/response
  logic        m0_valid;
  logic        m0_ready;
  logic [31:0] m0_addr;
  logic [31:0] m0_wdata;
  logic [3:0]  m0_wstrb;
  logic [31:0] m0_rdata;

  // Master 1 (loader) request/response
  logic        m1_valid;
  logic        m1_ready;
  logic [31:0] m1_addr;
  logic [31:0] m1_wdata;
  logic [3:0]  m1_wstrb;
  logic [31:0] m1_rdata;

  // RAM port
  logic          ram_en;
  logic [3:0]    ram_we;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_rdata;

  modport slave (
    input  m0_valid, m0_addr, m0_wdata, m0_wstrb,
    output m0_ready, m0_rdata,
    input  m1_valid, m1_addr, m1_wdata, m1_wstrb,
    output m1_ready, m1_rdata,
    output ram_en, ram_we, ram_addr, ram_wdata,
    input  ram_rdata
  );

  modport master (
    output m0_valid, m0_addr, m0_wdata, m0_wstrb,
    input  m0_ready, m0_rdata,
    output m1_valid, m1_addr, m1_wdata, m1_wstrb,
    input  m1_ready, m1_rdata,
    input  ram_en, ram_we, ram_addr, ram_wdata,
    output ram_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter in front of a single-port synchronous RAM.
// One transaction at a time: IDLE latches the winning request, ACCESS drives
// the RAM for one cycle, RDATA captures read data, RESP pulses ready.
// Out-of-range word addresses skip the RAM and answer with err at T+1.
`timescale 1ns/1ps

module mem_arbiter #(
  parameter int MEM_SIZE = 4096,
  parameter int AW       = 12
) (
  input  logic          clk,
  input  logic          resetn,
  mem_arbiter_if.slave  bus,
  output logic          busy,
  output logic          err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RDATA  = 2'd2,
    RESP   = 2'd3
  } state_e;

  state_e        state_q;
  logic          grant_q;     // master owning the current transaction
  logic          last_q;      // master granted most recently
  logic          ram_en_q;
  logic [3:0]    ram_we_q;
  logic [AW-1:0] ram_addr_q;
  logic [31:0]   ram_wdata_q;
  logic          m0_ready_q;
  logic          m1_ready_q;
  logic          err_q;
  logic [31:0]   m0_rdata_q;
  logic [31:0]   m1_rdata_q;

  logic          req_any;
  logic          grant_d;
  logic [31:0]   sel_addr;
  logic [31:0]   sel_wdata;
  logic [3:0]    sel_wstrb;
  logic          sel_oor;

  // Pick the winning master and mux its request fields.
  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    grant_d = 1'b0;
    if (bus.m0_valid && bus.m1_valid) begin
      grant_d = ~last_q;
    end else if (bus.m1_valid) begin
      grant_d = 1'b1;
    end
    req_any   = bus.m0_valid | bus.m1_valid;
    sel_addr  = grant_d ? bus.m1_addr  : bus.m0_addr;
    sel_wdata = grant_d ? bus.m1_wdata : bus.m0_wdata;
    sel_wstrb = grant_d ? bus.m1_wstrb : bus.m0_wstrb;
    sel_oor   = (sel_addr >> 2) >= 32'(MEM_SIZE);
  end

  // Transaction FSM with all outputs registered.
  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  // NOTE: the rdata holding registers are ordinary flops, not a memory, so
  // they take the asynchronous reset like everything else.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      grant_q     <= 1'b0;
      last_q      <= 1'b1;      // master 0 wins the first contention
      ram_en_q    <= 1'b0;
      ram_we_q    <= '0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      m0_ready_q  <= 1'b0;
      m1_ready_q  <= 1'b0;
      err_q       <= 1'b0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_any) begin
            grant_q <= grant_d;
            last_q  <= grant_d;
            if (sel_oor) begin
              // No RAM access: answer immediately, reads return zero.
              state_q <= RESP;
              err_q   <= 1'b1;
              if (grant_d) begin
                m1_ready_q <= 1'b1;
                if (sel_wstrb == 4'h0) m1_rdata_q <= '0;
              end else begin
                m0_ready_q <= 1'b1;
                if (sel_wstrb == 4'h0) m0_rdata_q <= '0;
              end
            end else begin
              state_q     <= ACCESS;
              ram_en_q    <= 1'b1;
              ram_we_q    <= sel_wstrb;
              ram_addr_q  <= sel_addr[AW+1:2];
              ram_wdata_q <= sel_wdata;
            end
          end
        end
        ACCESS: begin
          ram_en_q <= 1'b0;
          ram_we_q <= '0;
          if (ram_we_q == 4'h0) begin
            state_q <= RDATA;
          end else begin
            state_q <= RESP;
            if (grant_q) m1_ready_q <= 1'b1;
            else         m0_ready_q <= 1'b1;
          end
        end
        RDATA: begin
          state_q <= RESP;
          if (grant_q) begin
            m1_rdata_q <= bus.ram_rdata;
            m1_ready_q <= 1'b1;
          end else begin
            m0_rdata_q <= bus.ram_rdata;
            m0_ready_q <= 1'b1;
          end
        end
        RESP: begin
          state_q    <= IDLE;
          m0_ready_q <= 1'b0;
          m1_ready_q <= 1'b0;
          err_q      <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.ram_en    = ram_en_q;
  assign bus.ram_we    = ram_we_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_wdata = ram_wdata_q;
  assign bus.m0_ready  = m0_ready_q;
  assign bus.m1_ready  = m1_ready_q;
  assign bus.m0_rdata  = m0_rdata_q;
  assign bus.m1_rdata  = m1_rdata_q;
  assign err           = err_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a behavioural synchronous RAM sits on the
// RAM port, and each scenario task drives requests and checks latency,
// ready/err behaviour, RAM strobes and returned data against fixed values.
`timescale 1ns/1ps

module tb_mem_arbiter;

  logic clk = 1'b0;
  logic resetn;
  logic busy;
  logic err;

  int checks   = 0;
  int failures = 0;

  mem_arbiter_if #(.AW(12)) bus ();

  mem_arbiter #(.MEM_SIZE(4096), .AW(12)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus),
    .busy   (busy),
    .err    (err)
  );

  always #5 clk = ~clk;

  // Behavioural single-port RAM: read data one cycle after a read strobe.
  logic [31:0] mem [0:4095];
  initial bus.ram_rdata = '0;
  always @(posedge clk) begin
    if (bus.ram_en) begin
      if (bus.ram_we == 4'h0) begin
        bus.ram_rdata <= mem[bus.ram_addr];
      end else begin
        for (int b = 0; b < 4; b++)
          if (bus.ram_we[b]) mem[bus.ram_addr][8*b +: 8] <= bus.ram_wdata[8*b +: 8];
      end
    end
  end

  task automatic drive_master(input bit m, input logic v, input logic [31:0] a,
                              input logic [31:0] d, input logic [3:0] s);
    if (m) begin
      bus.m1_valid = v; bus.m1_addr = a; bus.m1_wdata = d; bus.m1_wstrb = s;
    end else begin
      bus.m0_valid = v; bus.m0_addr = a; bus.m0_wdata = d; bus.m0_wstrb = s;
    end
  endtask

  // One request from master m; latency counted in clock edges from the
  // request cycle. Ends with the FSM back in IDLE.
  task automatic issue(input bit m, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] wstrb, input int exp_lat, input bit exp_err,
                       input bit chk_rdata, input logic [31:0] exp_rdata, input string name);
    int          lat = 0;
    bit          saw_en = 0;
    bit          both = 0;
    bit          other = 0;
    logic        got_err = 1'b0;
    logic [31:0] got_rdata = '0;
    logic [11:0] acc_addr = '0;
    logic [3:0]  acc_we = '0;
    @(negedge clk);
    drive_master(m, 1'b1, addr, wdata, wstrb);
    for (int c = 1; c <= 10 && lat == 0; c++) begin
      @(posedge clk); #1;
      if (bus.ram_en) begin
        saw_en = 1; acc_addr = bus.ram_addr; acc_we = bus.ram_we;
      end
      if (bus.m0_ready && bus.m1_ready) both = 1;
      if (m ? bus.m0_ready : bus.m1_ready) other = 1;
      if (m ? bus.m1_ready : bus.m0_ready) begin
        lat = c; got_err = err; got_rdata = m ? bus.m1_rdata : bus.m0_rdata;
      end
    end
    drive_master(m, 1'b0, 32'h0, 32'h0, 4'h0);
    checks++;
    if (lat !== exp_lat) begin
      failures++;
      $display("FAIL %s latency: got %0d (0 = timeout) expected %0d", name, lat, exp_lat);
    end
    checks++;
    if (got_err !== exp_err) begin
      failures++;
      $display("FAIL %s err: got %0b expected %0b", name, got_err, exp_err);
    end
    checks++;
    if (both || other) begin
      failures++;
      $display("FAIL %s ready_exclusive: both=%0b other=%0b expected 0/0", name, both, other);
    end
    checks++;
    if (saw_en !== !exp_err) begin
      failures++;
      $display("FAIL %s ram_en_seen: got %0b expected %0b", name, saw_en, !exp_err);
    end
    if (!exp_err) begin
      checks++;
      if (acc_addr !== addr[13:2] || acc_we !== wstrb) begin
        failures++;
        $display("FAIL %s ram_access: addr=%h we=%h expected addr=%h we=%h",
                 name, acc_addr, acc_we, addr[13:2], wstrb);
      end
    end
    if (chk_rdata) begin
      checks++;
      if (got_rdata !== exp_rdata) begin
        failures++;
        $display("FAIL %s rdata: got %h expected %h", name, got_rdata, exp_rdata);
      end
    end
    @(posedge clk); #1;   // RESP -> IDLE
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if ({busy, err, bus.ram_en, bus.ram_we, bus.ram_addr, bus.ram_wdata,
         bus.m0_ready, bus.m1_ready, bus.m0_rdata, bus.m1_rdata} !== '0) begin
      failures++;
      $display("FAIL %s: busy=%b err=%b en=%b we=%h addr=%h wd=%h rdy=%b%b rd0=%h rd1=%h expected all 0",
               name, busy, err, bus.ram_en, bus.ram_we, bus.ram_addr, bus.ram_wdata,
               bus.m0_ready, bus.m1_ready, bus.m0_rdata, bus.m1_rdata);
    end
  endtask

  task automatic test_reset();
    drive_master(0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive_master(1, 1'b0, 32'h0, 32'h0, 4'h0);
    resetn = 1'b0;
    #12;
    check_reset_outputs("reset_state");
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_write_read();
    issue(0, 32'h10, 32'hDEADBEEF, 4'hF, 2, 0, 0, 32'h0, "m0_write");
    checks++;
    if (bus.m0_rdata !== 32'h0) begin
      failures++;
      $display("FAIL write_keeps_rdata: got %h expected 00000000", bus.m0_rdata);
    end
    issue(0, 32'h10, 32'h0, 4'h0, 3, 0, 1, 32'hDEADBEEF, "m0_read");
  endtask

  task automatic test_byte_write();
    mem[4] = 32'h11223344;
    issue(1, 32'h10, 32'h000000AA, 4'h1, 2, 0, 0, 32'h0, "m1_byte_write");
    issue(1, 32'h10, 32'h0, 4'h0, 3, 0, 1, 32'h112233AA, "m1_byte_read");
    checks++;
    if (bus.m0_rdata !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL other_master_keeps_rdata: got %h expected deadbeef", bus.m0_rdata);
    end
  endtask

  task automatic test_out_of_range();
    mem[4095] = 32'h55AA55AA;
    issue(0, 32'h3FFC, 32'h0, 4'h0, 3, 0, 1, 32'h55AA55AA, "last_word_read");
    issue(0, 32'h4000, 32'h0, 4'h0, 1, 1, 1, 32'h0, "oor_read");
    issue(1, 32'h4000, 32'h12345678, 4'hF, 1, 1, 1, 32'h112233AA, "oor_write");
  endtask

  task automatic test_contention();
    bit   order [4];
    int   first_edge = 0;
    int   n = 0;
    bit   both = 0;
    mem[8] = 32'hCAFEF00D;
    resetn = 1'b0;
    drive_master(0, 1'b1, 32'h10, 32'h0, 4'h0);
    drive_master(1, 1'b1, 32'h20, 32'h0, 4'h0);
    #12;
    @(negedge clk);
    resetn = 1'b1;
    for (int c = 1; c <= 40 && n < 4; c++) begin
      @(posedge clk); #1;
      if (bus.m0_ready && bus.m1_ready) both = 1;
      if (bus.m0_ready || bus.m1_ready) begin
        if (n == 0) first_edge = c;
        order[n] = bus.m1_ready;
        checks++;
        if ((bus.m1_ready ? bus.m1_rdata : bus.m0_rdata) !==
            (bus.m1_ready ? 32'hCAFEF00D : 32'h112233AA)) begin
          failures++;
          $display("FAIL contention_rdata[%0d]: m0=%h m1=%h", n, bus.m0_rdata, bus.m1_rdata);
        end
        n++;
      end
    end
    drive_master(0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive_master(1, 1'b0, 32'h0, 32'h0, 4'h0);
    @(posedge clk); #1;
    checks++;
    if (n !== 4 || {order[0], order[1], order[2], order[3]} !== 4'b0101) begin
      failures++;
      $display("FAIL contention_order: count=%0d order=%b%b%b%b expected 4 / 0101",
               n, order[0], order[1], order[2], order[3]);
    end
    checks++;
    if (both) begin
      failures++;
      $display("FAIL contention_ready_exclusive: both readies high, expected never");
    end
    checks++;
    if (first_edge !== 3) begin
      failures++;
      $display("FAIL first_after_reset_latency: got %0d expected 3", first_edge);
    end
  endtask

  task automatic test_reset_mid_read();
    bit saw_ready = 0;
    @(negedge clk);
    drive_master(0, 1'b1, 32'h10, 32'h0, 4'h0);
    @(posedge clk); #1;   // ACCESS
    @(posedge clk); #1;   // RDATA
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL mid_read_busy: got %b expected 1", busy);
    end
    resetn = 1'b0;
    #1;
    check_reset_outputs("mid_read_reset_async");
    drive_master(0, 1'b0, 32'h0, 32'h0, 4'h0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      if (bus.m0_ready || bus.m1_ready) saw_ready = 1;
    end
    checks++;
    if (saw_ready) begin
      failures++;
      $display("FAIL mid_read_no_ready: got ready pulse, expected none");
    end
    @(negedge clk);
    resetn = 1'b1;
    issue(0, 32'h10, 32'h0, 4'h0, 3, 0, 1, 32'h112233AA, "read_after_reset");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_read();
    test_byte_write();
    test_out_of_range();
    test_contention();
    test_reset_mid_read();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
